slow_clock_monitor: RTL and testbench
=====================================

// Module: slow_clock_monitor
// PURPOSE
//  Receive-side checker for a divided (slow) clock such as the Slow_Clock output.
//  Samples the asynchronous slow clock in the fast clkin domain and measures its period and high time in clkin cycles.
//  Declares lock once the period is stable and flags loss of clock.
//  Feeds status LEDs and self-checking lab benches.
// PARAMETERS
//  CNT_W       24   width of the period, high-time and gap counters
//  TOL         2    max |period - previous period| (clkin cycles) still counted as "stable"
//  LOCK_CNT    4    consecutive stable periods required to assert locked
//  TIMEOUT_CYC 1000 clkin cycles with no rising edge before timeout; must be < 2**CNT_W
// PORTS
//  clkin      in   1      fast reference clock; all logic on its rising edge
//  reset      in   1      asynchronous, active-low reset
//  sclk_in    in   1      slow clock under test, asynchronous to clkin
//  period     out  CNT_W  last measured period (rise to rise), clkin cycles
//  high_time  out  CNT_W  high time of that same period, clkin cycles
//  meas_valid out  1      1-cycle pulse when period/high_time update
//  locked     out  1      period stable for LOCK_CNT consecutive measurements
//  timeout    out  1      sticky: no rising edge for TIMEOUT_CYC cycles
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, all counters 0, sync flops 0, state IDLE.
//  Sync: 2-flop synchronizer, then a 3rd flop for edge detect.
//   rise = s2 & ~s3; fall = ~s2 & s3.
//   An edge on sclk_in is detected 3 clkin edges after it is sampled.
//  Counters:
//   gap: set to 1 on rise, else +1; saturates at 2**CNT_W-1.
//   hi: set to 1 on rise; +1 while s2=1; frozen into hi_lat on fall.
//  FSM IDLE -> ARMED -> MEAS <-> LOCKED:
//   IDLE:   wait for first rise -> ARMED. No measurement is made.
//   ARMED:  on next rise: period<=gap, high_time<=hi_lat, meas_valid=1,
//           stable_cnt<=0 -> MEAS.
//   MEAS:   on rise: update outputs as in ARMED.
//           If |gap-period|<=TOL, stable_cnt+1 (saturating); else stable_cnt<=0.
//           When stable_cnt reaches LOCK_CNT-1 with a stable sample: locked<=1 -> LOCKED.
//   LOCKED: on rise: update outputs. Any unstable sample: locked<=0,
//           stable_cnt<=0 -> MEAS.
//  Timeout (any state except IDLE):
//   When gap reaches TIMEOUT_CYC: timeout<=1, locked<=0 -> IDLE.
//   timeout stays sticky until reset. period and high_time hold their last values.
//  meas_valid: registered, high exactly one cycle per accepted rise. Never asserted in IDLE.
//  Duty edge cases:
//   A period with no fall (stuck high) reports high_time = period.
//   Glitches shorter than 1 clkin cycle may be missed; no filtering is required.
//  Simultaneous rise and gap==TIMEOUT_CYC: the rise wins (measurement taken, no timeout).
//  Mid-operation reset: immediate return to reset values; the first post-reset rise is discarded (IDLE).
//  Width: the subtraction for |gap-period| is CNT_W+1 bits signed. No wrap, because gap saturates.
// STRUCTURE
//  Shared package/header: state encodings (IDLE=0, ARMED=1, MEAS=2, LOCKED=3)
//  and default CNT_W/TOL/LOCK_CNT/TIMEOUT_CYC.
//  One sub-module: sync_edge_det (2-flop sync + edge flop; outputs level, rise, fall).
//  Counters, FSM and output registers stay in this module.
// TESTING (clkin period 20 ns; sclk_in driven by Slow_Clock or a bench task)
//  1. Hold reset=0 for 100 ns, toggling sclk_in -> all outputs stay 0; no meas_valid.
//  2. sclk_in period 10 cycles, 50% duty -> 2nd rise gives period=10, high_time=5,
//     meas_valid pulse 3 cycles after the sampled edge.
//     locked=1 at the 5th measurement (4 stable after first).
//  3. Locked at period 10, then one period of 13 (>TOL) -> locked=0 on that meas.
//     Relock after 4 further stable 10s.
//  4. Locked, then sclk_in held low -> timeout=1 and locked=0 exactly
//     TIMEOUT_CYC cycles after the last detected rise.
//     Resume clock -> timeout stays 1; period updates from the 2nd rise.
//  5. Period jitter 10/11/10/12 with TOL=2 -> all stable; locked asserts.
//     period tracks each value.
//  6. Assert reset mid-measurement (gap=6) -> outputs 0 at once.
//     After release, first rise ignored; first meas_valid on the second rise.

Source files
------------

// File: rtl/slow_clock_monitor_pkg.sv
// rtl/slow_clock_monitor_pkg.sv - shared state encoding and default parameters for the slow clock monitor
package slow_clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_MEAS   = 2'd2,
        ST_LOCKED = 2'd3
    } mon_state_t;

    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TOL         = 2;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer plus edge-detect flop for an asynchronous level
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain; s3 is the previous synchronized value used for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/slow_clock_monitor.sv
// rtl/slow_clock_monitor.sv - measures period/high time of a slow asynchronous clock, reports lock and loss of clock
module slow_clock_monitor
    import slow_clock_monitor_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             sclk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int SC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] TO_LIMIT  = TIMEOUT_CYC;
    localparam logic [CNT_W:0]   TOL_V     = TOL;
    localparam logic [SC_W-1:0]  LOCK_LAST = LOCK_CNT - 1;
    localparam logic [SC_W-1:0]  SC_ONE    = 1;

    logic level;
    logic rise;
    logic fall;

    sync_edge_det u_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (sclk_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    logic [CNT_W-1:0] gap;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] hi_lat;
    logic             fell_seen;
    logic [SC_W-1:0]  stable_cnt;

    mon_state_t state;
    mon_state_t state_nx;

    logic take_meas;
    logic clr_stable;
    logic inc_stable;
    logic set_locked;
    logic clr_locked;
    logic to_fire;

    // Gap is sign-extended by one bit so the difference never wraps; gap saturates
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]        mag;
    logic                  stable;

    assign diff   = $signed({1'b0, gap}) - $signed({1'b0, period});
    assign mag    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign stable = (mag <= TOL_V);

    // Rise-to-rise gap and high-time counters; fell_seen marks whether this period had a falling edge
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            gap       <= '0;
            hi        <= '0;
            hi_lat    <= '0;
            fell_seen <= 1'b0;
        end else begin
            if (rise)
                gap <= CNT_ONE;
            else if (gap != CNT_MAX)
                gap <= gap + CNT_ONE;

            if (rise)
                hi <= CNT_ONE;
            else if (level && hi != CNT_MAX)
                hi <= hi + CNT_ONE;

            if (fall)
                hi_lat <= hi;

            if (rise)
                fell_seen <= 1'b0;
            else if (fall)
                fell_seen <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next state and per-cycle control strobes; a rise always takes priority over timeout
    always_comb begin
        state_nx   = state;
        take_meas  = 1'b0;
        clr_stable = 1'b0;
        inc_stable = 1'b0;
        set_locked = 1'b0;
        clr_locked = 1'b0;
        to_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise)
                    state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (rise) begin
                    take_meas  = 1'b1;
                    clr_stable = 1'b1;
                    state_nx   = ST_MEAS;
                end else if (gap >= TO_LIMIT) begin
                    to_fire  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_MEAS: begin
                if (rise) begin
                    take_meas = 1'b1;
                    if (stable) begin
                        if (stable_cnt == LOCK_LAST) begin
                            set_locked = 1'b1;
                            state_nx   = ST_LOCKED;
                        end else begin
                            inc_stable = 1'b1;
                        end
                    end else begin
                        clr_stable = 1'b1;
                    end
                end else if (gap >= TO_LIMIT) begin
                    to_fire  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    take_meas = 1'b1;
                    if (!stable) begin
                        clr_locked = 1'b1;
                        clr_stable = 1'b1;
                        state_nx   = ST_MEAS;
                    end
                end else if (gap >= TO_LIMIT) begin
                    to_fire  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output and stability registers; a period without a fall reports the full period as high time
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            meas_valid <= take_meas;
            if (take_meas) begin
                period    <= gap;
                high_time <= fell_seen ? hi_lat : gap;
            end

            if (clr_stable)
                stable_cnt <= '0;
            else if (inc_stable && stable_cnt != LOCK_LAST)
                stable_cnt <= stable_cnt + SC_ONE;

            if (set_locked)
                locked <= 1'b1;
            else if (clr_locked || to_fire)
                locked <= 1'b0;

            if (to_fire)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb/tb_slow_clock_monitor.sv - directed self-checking bench for slow_clock_monitor
`timescale 1ns/1ps
module tb_slow_clock_monitor;

    logic        clkin = 1'b0;
    logic        reset = 1'b0;
    logic        sclk_in = 1'b0;
    logic [23:0] period;
    logic [23:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] log_per  [64];
    logic [23:0] log_hi   [64];
    logic        log_lock [64];
    int          meas_n = 0;
    int          base;

    slow_clock_monitor dut (
        .clkin      (clkin),
        .reset      (reset),
        .sclk_in    (sclk_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #10 clkin = ~clkin;

    // Record every measurement pulse away from the active edge
    always @(negedge clkin) begin
        if (meas_valid) begin
            if (meas_n < 64) begin
                log_per[meas_n]  = period;
                log_hi[meas_n]   = high_time;
                log_lock[meas_n] = locked;
            end
            meas_n = meas_n + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_period(input int p, input int h);
        sclk_in = 1'b1;
        repeat (h) @(negedge clkin);
        sclk_in = 1'b0;
        repeat (p - h) @(negedge clkin);
    endtask

    task automatic apply_reset();
        @(negedge clkin);
        reset   = 1'b0;
        sclk_in = 1'b0;
        repeat (2) @(negedge clkin);
        reset = 1'b1;
        repeat (2) @(negedge clkin);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        sclk_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkin);
            sclk_in = ~sclk_in;
            #1;
            n_checks++;
            if ({period, high_time, meas_valid, locked, timeout} !== 51'd0)
                $display("FAIL reset_outputs[%0d]: got %h expected 0", i,
                         {period, high_time, meas_valid, locked, timeout});
            else
                n_pass++;
        end
        @(negedge clkin);
        sclk_in = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clkin);
    endtask

    task automatic test_basic_lock();
        drive_period(10, 5);
        base    = meas_n;
        sclk_in = 1'b1;
        @(posedge clkin);
        @(posedge clkin);
        #1;
        n_checks++;
        if (meas_valid !== 1'b0) $display("FAIL lat_early: got %b expected 0", meas_valid);
        else n_pass++;
        @(posedge clkin);
        #1;
        n_checks++;
        if ({meas_valid, period, high_time} !== {1'b1, 24'd10, 24'd5})
            $display("FAIL lat_meas: got mv=%b per=%0d hi=%0d expected mv=1 per=10 hi=5",
                     meas_valid, period, high_time);
        else n_pass++;
        @(posedge clkin);
        #1;
        n_checks++;
        if (meas_valid !== 1'b0) $display("FAIL pulse_width: got %b expected 0", meas_valid);
        else n_pass++;
        @(negedge clkin);
        @(negedge clkin);
        sclk_in = 1'b0;
        repeat (5) @(negedge clkin);
        repeat (4) drive_period(10, 5);
        #1;
        n_checks++;
        if (meas_n - base !== 5) $display("FAIL basic_count: got %0d expected 5", meas_n - base);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({log_per[base+i], log_hi[base+i], log_lock[base+i]} !== {24'd10, 24'd5, (i == 4)})
                $display("FAIL basic_meas[%0d]: got per=%0d hi=%0d lock=%b expected per=10 hi=5 lock=%b",
                         i, log_per[base+i], log_hi[base+i], log_lock[base+i], (i == 4));
            else n_pass++;
        end
    endtask

    task automatic test_unlock_relock();
        base = meas_n;
        drive_period(13, 6);
        repeat (6) drive_period(10, 5);
        #1;
        n_checks++;
        if (meas_n - base !== 7) $display("FAIL unlock_count: got %0d expected 7", meas_n - base);
        else n_pass++;
        n_checks++;
        if (log_lock[base] !== 1'b1) $display("FAIL unlock_pre: got lock=%b expected 1", log_lock[base]);
        else n_pass++;
        n_checks++;
        if ({log_per[base+1], log_hi[base+1], log_lock[base+1]} !== {24'd13, 24'd6, 1'b0})
            $display("FAIL unlock_13: got per=%0d hi=%0d lock=%b expected per=13 hi=6 lock=0",
                     log_per[base+1], log_hi[base+1], log_lock[base+1]);
        else n_pass++;
        n_checks++;
        if (log_lock[base+5] !== 1'b0) $display("FAIL relock_early: got lock=%b expected 0", log_lock[base+5]);
        else n_pass++;
        n_checks++;
        if ({log_per[base+6], log_lock[base+6]} !== {24'd10, 1'b1})
            $display("FAIL relock: got per=%0d lock=%b expected per=10 lock=1",
                     log_per[base+6], log_lock[base+6]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        sclk_in = 1'b1;
        repeat (3) @(negedge clkin);
        #1;
        n_checks++;
        if ({meas_valid, locked} !== 2'b11)
            $display("FAIL to_last_meas: got mv=%b lock=%b expected mv=1 lock=1", meas_valid, locked);
        else n_pass++;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge clkin);
            if (n == 5) sclk_in = 1'b0;
            if (n == 999) begin
                n_checks++;
                if (timeout !== 1'b0) $display("FAIL to_early: got %b expected 0", timeout);
                else n_pass++;
            end
            if (n == 1000) begin
                n_checks++;
                if ({timeout, locked} !== 2'b10)
                    $display("FAIL to_fire: got to=%b lock=%b expected to=1 lock=0", timeout, locked);
                else n_pass++;
            end
        end
        n_checks++;
        if ({period, high_time} !== {24'd10, 24'd5})
            $display("FAIL to_hold: got per=%0d hi=%0d expected per=10 hi=5", period, high_time);
        else n_pass++;
        base = meas_n;
        repeat (3) drive_period(12, 4);
        #1;
        n_checks++;
        if (meas_n - base !== 2) $display("FAIL resume_count: got %0d expected 2", meas_n - base);
        else n_pass++;
        n_checks++;
        if ({log_per[base], log_hi[base], timeout} !== {24'd12, 24'd4, 1'b1})
            $display("FAIL resume_meas: got per=%0d hi=%0d to=%b expected per=12 hi=4 to=1",
                     log_per[base], log_hi[base], timeout);
        else n_pass++;
    endtask

    task automatic test_jitter();
        int lens [6];
        int highs [6];
        lens  = '{10, 11, 10, 12, 10, 10};
        highs = '{5, 3, 7, 2, 6, 5};
        apply_reset();
        base = meas_n;
        for (int i = 0; i < 6; i++) drive_period(lens[i], highs[i]);
        #1;
        n_checks++;
        if (meas_n - base !== 5) $display("FAIL jitter_count: got %0d expected 5", meas_n - base);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({log_per[base+i], log_hi[base+i], log_lock[base+i]} !==
                {lens[i][23:0], highs[i][23:0], (i == 4)})
                $display("FAIL jitter_meas[%0d]: got per=%0d hi=%0d lock=%b expected per=%0d hi=%0d lock=%b",
                         i, log_per[base+i], log_hi[base+i], log_lock[base+i], lens[i], highs[i], (i == 4));
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        base = meas_n;
        drive_period(10, 5);
        drive_period(10, 5);
        #1;
        n_checks++;
        if ({meas_n - base, period} !== {32'd1, 24'd10})
            $display("FAIL mid_pre: got count=%0d per=%0d expected count=1 per=10", meas_n - base, period);
        else n_pass++;
        sclk_in = 1'b1;
        repeat (8) @(negedge clkin);
        #5;
        reset   = 1'b0;
        sclk_in = 1'b0;
        #1;
        n_checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== 51'd0)
            $display("FAIL mid_reset_outputs: got %h expected 0", {period, high_time, meas_valid, locked, timeout});
        else n_pass++;
        repeat (2) @(negedge clkin);
        reset = 1'b1;
        base  = meas_n;
        drive_period(10, 5);
        #1;
        n_checks++;
        if (meas_n - base !== 0) $display("FAIL post_reset_first: got %0d expected 0", meas_n - base);
        else n_pass++;
        drive_period(10, 5);
        #1;
        n_checks++;
        if ({meas_n - base, log_per[base], log_hi[base]} !== {32'd1, 24'd10, 24'd5})
            $display("FAIL post_reset_second: got count=%0d per=%0d hi=%0d expected count=1 per=10 hi=5",
                     meas_n - base, log_per[base], log_hi[base]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_unlock_relock();
        test_timeout();
        test_jitter();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
